// File: rtl/rca_pipe_adder.sv
// Pipelined segmented ripple-carry adder: one BLOCK-bit carry segment per stage,
// valid/ready flow control, optional per-beat cut of the low segment-boundary carries.
module rca_pipe_adder #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned BLOCK       = 4,
    parameter int unsigned APPROX_BLKS = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic             approx_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o
);

    localparam int unsigned STAGES = WIDTH / BLOCK;
    localparam int unsigned LAST   = STAGES - 1;

    if (WIDTH % BLOCK != 0) begin : g_bad_block
        $error("rca_pipe_adder: WIDTH must be a multiple of BLOCK");
    end
    if (APPROX_BLKS >= STAGES) begin : g_bad_approx
        $error("rca_pipe_adder: APPROX_BLKS must be below WIDTH/BLOCK");
    end

    // One beat in flight: unresolved operand bits ride along with the partial sum.
    typedef struct packed {
        logic             vld;
        logic             approx;
        logic             cy;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
    } beat_t;

    logic advance_c;

    // The whole pipe moves together; holes are shifted like real beats.
    assign advance_c = !valid_o || ready_i;
    assign ready_o   = advance_c;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned KU = k;

        beat_t             src;
        logic              cin;
        logic [BLOCK:0]    seg;
        logic [WIDTH-1:0]  s_next;

        if (k == 0) begin : g_in
            assign src = '{vld: valid_i, approx: approx_i, cy: c_i,
                           a: a_i, b: b_i, s: '0};
            assign cin = src.cy;
        end else begin : g_chain
            // Boundaries 1..APPROX_BLKS lose their carry on approximate beats.
            localparam bit CUT = (KU <= APPROX_BLKS);
            assign src = g_stage[k-1].g_reg.q;
            assign cin = src.cy & ~(src.approx & CUT);
        end

        always_comb begin
            seg    = (BLOCK+1)'(BLOCK'(src.a >> (KU * BLOCK)))
                   + (BLOCK+1)'(BLOCK'(src.b >> (KU * BLOCK)))
                   + (BLOCK+1)'(cin);
            s_next = src.s | (WIDTH'(seg[BLOCK-1:0]) << (KU * BLOCK));
        end

        if (KU < LAST) begin : g_reg
            beat_t q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    q <= '0;
                end else if (advance_c) begin
                    q <= '{vld: src.vld, approx: src.approx, cy: seg[BLOCK],
                           a: src.a, b: src.b, s: s_next};
                end
            end
        end else begin : g_out
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_o <= 1'b0;
                    s_o     <= '0;
                    c_o     <= 1'b0;
                end else if (advance_c) begin
                    valid_o <= src.vld;
                    s_o     <= s_next;
                    c_o     <= seg[BLOCK];
                end
            end
        end
    end

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Self-checking bench for rca_pipe_adder: directed vectors plus randomized traffic
// against an arithmetic reference model tracked per pipeline slot.
module tb_rca_pipe_adder;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned BLOCK       = 4;
    localparam int unsigned APPROX_BLKS = 2;
    localparam int unsigned STAGES      = WIDTH / BLOCK;
    localparam int unsigned LAST        = STAGES - 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             c_i;
    logic             approx_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] s_o;
    logic             c_o;

    int n_tests = 0;
    int n_fail  = 0;

    rca_pipe_adder #(
        .WIDTH      (WIDTH),
        .BLOCK      (BLOCK),
        .APPROX_BLKS(APPROX_BLKS)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .c_i     (c_i),
        .approx_i(approx_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .s_o     (s_o),
        .c_o     (c_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference sum: exact is plain addition; approx adds the region above the cuts
    // as one number and each low segment independently (carry-out discarded).
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic c, input logic ap);
        logic [WIDTH:0] r;
        logic [BLOCK:0] sg;
        int unsigned    lo;
        if (!ap || APPROX_BLKS == 0)
            return (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(c);
        lo = APPROX_BLKS * BLOCK;
        r  = ((WIDTH+1)'(a >> lo) + (WIDTH+1)'(b >> lo)) << lo;
        for (int j = 0; j < int'(APPROX_BLKS); j++) begin
            sg = (BLOCK+1)'(BLOCK'(a >> (j * BLOCK))) + (BLOCK+1)'(BLOCK'(b >> (j * BLOCK)))
               + (BLOCK+1)'((j == 0) ? c : 1'b0);
            r[j*BLOCK +: BLOCK] = sg[BLOCK-1:0];
        end
        return r;
    endfunction

    typedef struct {
        bit               v;
        logic [WIDTH-1:0] s;
        logic             c;
    } exp_t;

    exp_t mdl[STAGES];

    // Slot model: each beat spends STAGES cycles in flight, everything frozen while stalled.
    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(STAGES); i++) mdl[i].v = 1'b0;
        end else if (!mdl[LAST].v || ready_i) begin
            for (int i = int'(LAST); i > 0; i--) mdl[i] = mdl[i-1];
            mdl[0].v = valid_i;
            {mdl[0].c, mdl[0].s} = ref_add(a_i, b_i, c_i, approx_i);
        end
    end

    task automatic drive(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic ap, input bit rdy);
        valid_i  = v;
        a_i      = a;
        b_i      = b;
        c_i      = c;
        approx_i = ap;
        ready_i  = rdy;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(0, '0, '0, 0, 0, 0);
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        n_tests++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        n_tests++;
        if (s_o !== '0) begin n_fail++; $display("FAIL reset_sum got=%h exp=0000", s_o); end
        n_tests++;
        if (c_o !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", c_o); end
        n_tests++;
        if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta[5] = '{16'hFFFF, 16'h00FF, 16'h00FF, 16'hF000, 16'h0FFF};
        logic [WIDTH-1:0] tb[5] = '{16'h0001, 16'h0001, 16'h0001, 16'h1000, 16'h0000};
        logic             tc[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic             tp[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [WIDTH-1:0] es[5] = '{16'h0000, 16'h0100, 16'h00F0, 16'h0000, 16'h1000};
        logic             ec[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int v = 0; v < 5; v++) begin
            drive(1, ta[v], tb[v], tc[v], tp[v], 1);
            tick();
            drive(0, '0, '0, 0, 0, 1);
            for (int cyc = 1; cyc < int'(STAGES); cyc++) begin
                tick();
                n_tests++;
                if (valid_o !== ((cyc == int'(LAST)) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL dir%0d_latency cyc=%0d valid got=%b", v, cyc, valid_o);
                end
            end
            n_tests++;
            if (s_o !== es[v]) begin n_fail++; $display("FAIL dir%0d_sum got=%h exp=%h", v, s_o, es[v]); end
            n_tests++;
            if (c_o !== ec[v]) begin n_fail++; $display("FAIL dir%0d_cout got=%b exp=%b", v, c_o, ec[v]); end
            tick();
            n_tests++;
            if (valid_o !== 1'b0) begin n_fail++; $display("FAIL dir%0d_drop got=%b exp=0", v, valid_o); end
        end
    endtask

    task automatic test_back_to_back();
        int nv = 0, first = -1, last = -1;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) drive(1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1);
            else       drive(0, '0, '0, 0, 0, 1);
            tick();
            n_tests++;
            if (valid_o !== mdl[LAST].v) begin
                n_fail++; $display("FAIL b2b_valid i=%0d got=%b exp=%b", i, valid_o, mdl[LAST].v);
            end
            if (mdl[LAST].v) begin
                n_tests++;
                if ({c_o, s_o} !== {mdl[LAST].c, mdl[LAST].s}) begin
                    n_fail++; $display("FAIL b2b_data i=%0d got=%b_%h exp=%b_%h", i, c_o, s_o, mdl[LAST].c, mdl[LAST].s);
                end
            end
            if (valid_o === 1'b1) begin
                nv++;
                if (first < 0) first = i;
                last = i;
            end
        end
        n_tests++;
        if (nv != 8 || last - first != 7) begin
            n_fail++; $display("FAIL b2b_run got=%0d beats span=%0d exp=8 span=7", nv, last - first);
        end
    endtask

    task automatic test_backpressure();
        int hs = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 0);
            #1;
            n_tests++;
            if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready i=%0d got=%b exp=0", i, ready_o); end
            tick();
            n_tests++;
            if (valid_o !== 1'b1 || {c_o, s_o} !== {mdl[LAST].c, mdl[LAST].s}) begin
                n_fail++; $display("FAIL bp_hold i=%0d got=%b_%b_%h exp=1_%b_%h", i, valid_o, c_o, s_o, mdl[LAST].c, mdl[LAST].s);
            end
        end
        drive(0, '0, '0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (valid_o !== mdl[LAST].v) begin
                n_fail++; $display("FAIL bp_drain_valid i=%0d got=%b exp=%b", i, valid_o, mdl[LAST].v);
            end
            if (mdl[LAST].v) begin
                n_tests++;
                if ({c_o, s_o} !== {mdl[LAST].c, mdl[LAST].s}) begin
                    n_fail++; $display("FAIL bp_drain_data i=%0d got=%b_%h exp=%b_%h", i, c_o, s_o, mdl[LAST].c, mdl[LAST].s);
                end
            end
            if (valid_o === 1'b1 && ready_i) hs++;
            tick();
        end
        n_tests++;
        if (hs != 4) begin n_fail++; $display("FAIL bp_count got=%0d exp=4", hs); end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            drive(1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1);
            tick();
        end
        rst_i = 1'b1;
        drive(0, '0, '0, 0, 0, 1);
        tick();
        rst_i = 1'b0;
        n_tests++;
        if ({valid_o, c_o, s_o} !== '0) begin
            n_fail++; $display("FAIL rst_mid got=%b_%b_%h exp=0_0_0000", valid_o, c_o, s_o);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_stale i=%0d got=%b exp=0", i, valid_o); end
        end
        drive(1, 16'h1234, 16'h4321, 0, 0, 1);
        tick();
        drive(0, '0, '0, 0, 0, 1);
        for (int i = 0; i < int'(LAST); i++) tick();
        n_tests++;
        if ({valid_o, c_o, s_o} !== {1'b1, 1'b0, 16'h5555}) begin
            n_fail++; $display("FAIL rst_new got=%b_%b_%h exp=1_0_5555", valid_o, c_o, s_o);
        end
        tick();
    endtask

    task automatic test_holes();
        bit pat[8];
        bit ev;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                pat[i] = (i % 2 == 0);
                drive(pat[i], WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1);
            end else begin
                drive(0, '0, '0, 0, 0, 1);
            end
            tick();
            ev = (i >= int'(LAST) && i - int'(LAST) < 8) ? pat[i - int'(LAST)] : 1'b0;
            n_tests++;
            if (valid_o !== ev) begin n_fail++; $display("FAIL holes_valid i=%0d got=%b exp=%b", i, valid_o, ev); end
            if (ev) begin
                n_tests++;
                if ({c_o, s_o} !== {mdl[LAST].c, mdl[LAST].s}) begin
                    n_fail++; $display("FAIL holes_data i=%0d got=%b_%h exp=%b_%h", i, c_o, s_o, mdl[LAST].c, mdl[LAST].s);
                end
            end
        end
    endtask

    task automatic test_random_flow();
        for (int i = 0; i < 86; i++) begin
            if (i < 80) drive(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                              ($urandom_range(0, 3) != 0));
            else        drive(0, '0, '0, 0, 0, 1);
            #1;
            n_tests++;
            if (ready_o !== (!mdl[LAST].v || ready_i)) begin
                n_fail++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, ready_o, !mdl[LAST].v || ready_i);
            end
            tick();
            n_tests++;
            if (valid_o !== mdl[LAST].v) begin
                n_fail++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, valid_o, mdl[LAST].v);
            end
            if (mdl[LAST].v) begin
                n_tests++;
                if ({c_o, s_o} !== {mdl[LAST].c, mdl[LAST].s}) begin
                    n_fail++; $display("FAIL rnd_data i=%0d got=%b_%h exp=%b_%h", i, c_o, s_o, mdl[LAST].c, mdl[LAST].s);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(STAGES); i++) mdl[i] = '{v: 1'b0, s: '0, c: 1'b0};
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_holes();
        test_random_flow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
